// File: rtl/mem_initiator.sv
// Initiator end of the memory valid/ready bus: a command FIFO feeding a
// single-outstanding request FSM, with read-data capture and a request timeout.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module mem_initiator #(
    parameter int WIDTH      = `WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr_rd,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wdata,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    output logic                  valid,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  err,
    output logic                  busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] LAST_WAIT  = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic                  is_write;
        logic [ADDR_WIDTH-1:0] address;
        logic [WIDTH-1:0]      data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_t;

    cmd_t            fifo_mem [DEPTH];
    cmd_t            head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   wait_cnt;
    logic [TW-1:0]   wait_cnt_next;

    logic                  valid_next;
    logic                  wr_rd_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [WIDTH-1:0]      wdata_next;
    logic                  rsp_valid_next;
    logic [WIDTH-1:0]      rsp_rdata_next;
    logic                  err_next;

    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr];
    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{is_write: cmd_wr_rd, address: cmd_addr, data: cmd_wdata};
        end
    end

    // Bus fields are cleared together with valid so they never carry stale values.
    always_comb begin
        state_next     = state;
        wait_cnt_next  = wait_cnt;
        pop            = 1'b0;
        valid_next     = valid;
        wr_rd_next     = wr_rd;
        addr_next      = addr;
        wdata_next     = wdata;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata;
        err_next       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop           = 1'b1;
                    valid_next    = 1'b1;
                    wr_rd_next    = head.is_write;
                    addr_next     = head.address;
                    wdata_next    = head.is_write ? head.data : '0;
                    wait_cnt_next = '0;
                    state_next    = REQ;
                end
            end
            REQ: begin
                if (ready) begin
                    valid_next = 1'b0;
                    wr_rd_next = 1'b0;
                    addr_next  = '0;
                    wdata_next = '0;
                    if (!wr_rd) begin
                        rsp_valid_next = 1'b1;
                        rsp_rdata_next = rdata;
                    end
                    state_next = GAP;
                end else if (wait_cnt == LAST_WAIT) begin
                    valid_next = 1'b0;
                    wr_rd_next = 1'b0;
                    addr_next  = '0;
                    wdata_next = '0;
                    err_next   = 1'b1;
                    state_next = GAP;
                end else begin
                    wait_cnt_next = wait_cnt + TW'(1);
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // cmd_ready and busy are registered from next-state values so they line up with count/state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            wr_rd     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count     <= count_next;
            cmd_ready <= (count_next != FULL_COUNT);
            busy      <= (state_next != IDLE) || (count_next != '0);
            valid     <= valid_next;
            wr_rd     <= wr_rd_next;
            addr      <= addr_next;
            wdata     <= wdata_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            err       <= err_next;
        end
    end

`ifndef SYNTHESIS
    a_idle_fields_zero: assert property (@(posedge clk) disable iff (rst)
        !valid |-> (!wr_rd && addr == '0 && wdata == '0));
    a_rsp_single_pulse: assert property (@(posedge clk) disable iff (rst)
        rsp_valid |=> !rsp_valid);
    a_err_single_pulse: assert property (@(posedge clk) disable iff (rst)
        err |=> !err);
    a_gap_after_request: assert property (@(posedge clk) disable iff (rst)
        $fell(valid) |=> !valid);
`endif

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: transaction-level model with a per-cycle
// compare process, a small memory responder, and directed scenarios with literal checks.
module tb_mem_initiator;

    localparam int WIDTH      = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr_rd;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        wr_rd;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic        valid;
    logic        ready = 1'b0;
    logic [7:0]  rdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        err;
    logic        busy;

    mem_initiator #(
        .WIDTH(WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH(DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr_rd(cmd_wr_rd),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .wr_rd(wr_rd),
        .addr(addr),
        .wdata(wdata),
        .valid(valid),
        .ready(ready),
        .rdata(rdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Memory responder: ready rises once valid has been seen for more than ack_delay cycles.
    logic [7:0] mem [16] = '{default: 8'h00};
    int ack_delay   = 1;
    bit toggle_idle = 1'b0;
    int seen        = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            seen++;
            ready = (seen > ack_delay);
            rdata = mem[addr];
        end else begin
            seen  = 0;
            ready = toggle_idle ? ~ready : 1'b0;
            rdata = 8'h5C;
        end
    end

    always @(posedge clk) begin
        if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1 && wr_rd === 1'b1) begin
            mem[addr] <= wdata;
        end
    end

    // Reference model: pending-command queue plus the bus phase of the single outstanding request.
    typedef struct {
        bit         wr;
        logic [3:0] a;
        logic [7:0] d;
    } cmd_s;

    cmd_s q[$];
    cmd_s cur;
    int   phase  = 0;
    int   waited = 0;
    bit   check_en = 1'b0;

    logic       exp_valid     = 1'b0;
    logic       exp_wr_rd     = 1'b0;
    logic [3:0] exp_addr      = 4'h0;
    logic [7:0] exp_wdata     = 8'h00;
    logic       exp_rsp_valid = 1'b0;
    logic [7:0] exp_rsp_rdata = 8'h00;
    logic       exp_err       = 1'b0;
    logic       exp_cmd_ready = 1'b0;
    logic       exp_busy      = 1'b0;

    always @(posedge clk) begin
        bit take;
        take = 1'b0;
        if (rst === 1'b1) begin
            q.delete();
            phase         = 0;
            exp_valid     = 1'b0;
            exp_wr_rd     = 1'b0;
            exp_addr      = 4'h0;
            exp_wdata     = 8'h00;
            exp_rsp_valid = 1'b0;
            exp_rsp_rdata = 8'h00;
            exp_err       = 1'b0;
            exp_cmd_ready = 1'b0;
            exp_busy      = 1'b0;
            check_en      = 1'b1;
        end else begin
            take          = (cmd_valid === 1'b1) && exp_cmd_ready;
            exp_rsp_valid = 1'b0;
            exp_err       = 1'b0;
            if (phase == 0) begin
                if (q.size() > 0) begin
                    cur       = q.pop_front();
                    exp_valid = 1'b1;
                    exp_wr_rd = cur.wr;
                    exp_addr  = cur.a;
                    exp_wdata = cur.wr ? cur.d : 8'h00;
                    waited    = 0;
                    phase     = 1;
                end
            end else if (phase == 1) begin
                if (ready === 1'b1) begin
                    if (!cur.wr) begin
                        exp_rsp_valid = 1'b1;
                        exp_rsp_rdata = rdata;
                    end
                    exp_valid = 1'b0;
                    exp_wr_rd = 1'b0;
                    exp_addr  = 4'h0;
                    exp_wdata = 8'h00;
                    phase     = 2;
                end else begin
                    waited++;
                    if (waited == TIMEOUT) begin
                        exp_err   = 1'b1;
                        exp_valid = 1'b0;
                        exp_wr_rd = 1'b0;
                        exp_addr  = 4'h0;
                        exp_wdata = 8'h00;
                        phase     = 2;
                    end
                end
            end else begin
                phase = 0;
            end
            if (take) begin
                q.push_back('{cmd_wr_rd, cmd_addr, cmd_wdata});
            end
            exp_cmd_ready = (q.size() < DEPTH);
            exp_busy      = (phase != 0) || (q.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("valid", 32'(valid), 32'(exp_valid));
            checkOutput("wr_rd", 32'(wr_rd), 32'(exp_wr_rd));
            checkOutput("addr", 32'(addr), 32'(exp_addr));
            checkOutput("wdata", 32'(wdata), 32'(exp_wdata));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_rsp_rdata));
            checkOutput("err", 32'(err), 32'(exp_err));
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
            checkOutput("busy", 32'(busy), 32'(exp_busy));
        end
    end

    // Episode monitor: records every valid-high stretch for literal checks.
    int         ep_len[$];
    logic [3:0] ep_addr[$];
    logic       ep_wr[$];
    logic [7:0] ep_data[$];
    int         cur_len   = 0;
    int         rsp_count = 0;
    int         err_count = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (cur_len == 0) begin
                ep_addr.push_back(addr);
                ep_wr.push_back(wr_rd);
                ep_data.push_back(wdata);
            end
            cur_len++;
        end else if (cur_len != 0) begin
            ep_len.push_back(cur_len);
            cur_len = 0;
        end
        if (rsp_valid === 1'b1) rsp_count++;
        if (err === 1'b1) err_count++;
    end

    task automatic boundFail(input string name, input int n, input int budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("[TB] FAIL %s: waited %0d cycles, required fewer than %0d", name, n, budget);
        end
    endtask

    // Offers one command starting at a negedge and returns at the negedge after acceptance.
    task automatic applyStimulus(input bit wr, input logic [3:0] a, input logic [7:0] d);
        int n;
        cmd_valid = 1'b1;
        cmd_wr_rd = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        boundFail("cmd_accept", n, 200);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || valid !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        boundFail("drain", n, budget);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_ep;
        int base_rsp;
        int base_err;
        int n;
        logic [3:0] order [6];

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr_rd = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("cmd_ready_after_reset", 32'(cmd_ready), 32'h1);

        // Single write, memory acks one cycle after valid.
        $display("[TB] write A5 to address 3");
        ack_delay = 1;
        base_ep   = ep_len.size();
        base_rsp  = rsp_count;
        applyStimulus(1'b1, 4'd3, 8'hA5);
        waitDrain(100);
        checkOutput("wr_episodes", 32'(ep_len.size() - base_ep), 32'd1);
        checkOutput("wr_valid_len", 32'(ep_len[base_ep]), 32'd2);
        checkOutput("wr_addr", 32'(ep_addr[base_ep]), 32'd3);
        checkOutput("wr_dir", 32'(ep_wr[base_ep]), 32'd1);
        checkOutput("wr_data", 32'(ep_data[base_ep]), 32'hA5);
        checkOutput("wr_no_rsp", 32'(rsp_count - base_rsp), 32'd0);

        // Write then read back the same address.
        $display("[TB] write then read address 3");
        base_ep  = ep_len.size();
        base_rsp = rsp_count;
        applyStimulus(1'b1, 4'd3, 8'hA5);
        applyStimulus(1'b0, 4'd3, 8'h00);
        waitDrain(100);
        checkOutput("rd_rsp_pulses", 32'(rsp_count - base_rsp), 32'd1);
        checkOutput("rd_rsp_rdata", 32'(rsp_rdata), 32'hA5);
        checkOutput("rd_episodes", 32'(ep_len.size() - base_ep), 32'd2);
        checkOutput("rd_dir", 32'(ep_wr[base_ep + 1]), 32'd0);

        // Fill the FIFO behind a slow request; the fifth command waits for space.
        $display("[TB] FIFO fill with slow memory");
        ack_delay = 10;
        base_ep   = ep_len.size();
        base_rsp  = rsp_count;
        base_err  = err_count;
        applyStimulus(1'b1, 4'd0, 8'h10);
        applyStimulus(1'b1, 4'd1, 8'h11);
        applyStimulus(1'b1, 4'd2, 8'h22);
        applyStimulus(1'b0, 4'd1, 8'h00);
        applyStimulus(1'b0, 4'd2, 8'h00);
        checkOutput("full_cmd_ready", 32'(cmd_ready), 32'h0);
        applyStimulus(1'b1, 4'd5, 8'h55);
        waitDrain(400);
        order = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2, 4'd5};
        checkOutput("fill_episodes", 32'(ep_len.size() - base_ep), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("fill_order_%0d", i), 32'(ep_addr[base_ep + i]), 32'(order[i]));
        end
        checkOutput("fill_rsp_pulses", 32'(rsp_count - base_rsp), 32'd2);
        checkOutput("fill_last_rdata", 32'(rsp_rdata), 32'h22);
        checkOutput("fill_no_err", 32'(err_count - base_err), 32'd0);

        // Memory never answers: the request times out and the next one proceeds.
        $display("[TB] timeout then recovery");
        ack_delay = 1000;
        base_ep   = ep_len.size();
        base_rsp  = rsp_count;
        base_err  = err_count;
        applyStimulus(1'b0, 4'd7, 8'h00);
        applyStimulus(1'b1, 4'd8, 8'h99);
        n = 0;
        while (err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        boundFail("timeout_err_seen", n, 100);
        ack_delay = 1;
        waitDrain(100);
        checkOutput("to_valid_len", 32'(ep_len[base_ep]), 32'd16);
        checkOutput("to_err_pulses", 32'(err_count - base_err), 32'd1);
        checkOutput("to_next_addr", 32'(ep_addr[base_ep + 1]), 32'd8);
        checkOutput("to_no_rsp", 32'(rsp_count - base_rsp), 32'd0);

        // Stray ready while idle must not capture or respond.
        $display("[TB] ready toggling outside requests");
        toggle_idle = 1'b1;
        base_ep     = ep_len.size();
        base_rsp    = rsp_count;
        repeat (6) @(negedge clk);
        checkOutput("idle_no_rsp", 32'(rsp_count - base_rsp), 32'd0);
        checkOutput("idle_rdata_held", 32'(rsp_rdata), 32'h22);
        applyStimulus(1'b0, 4'd3, 8'h00);
        waitDrain(100);
        repeat (4) @(negedge clk);
        toggle_idle = 1'b0;
        @(negedge clk);
        checkOutput("toggle_rsp_pulses", 32'(rsp_count - base_rsp), 32'd1);
        checkOutput("toggle_rdata", 32'(rsp_rdata), 32'hA5);
        checkOutput("toggle_episodes", 32'(ep_len.size() - base_ep), 32'd1);

        // Reset in the middle of a request with another command queued.
        $display("[TB] reset during request");
        ack_delay = 1000;
        base_ep   = ep_addr.size();
        applyStimulus(1'b1, 4'd9, 8'h77);
        applyStimulus(1'b1, 4'd10, 8'h88);
        n = 0;
        while (valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        boundFail("mid_req_valid_seen", n, 50);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(valid), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        rst       = 1'b0;
        ack_delay = 1;
        repeat (5) @(negedge clk);
        checkOutput("post_rst_valid", 32'(valid), 32'h0);
        checkOutput("post_rst_busy", 32'(busy), 32'h0);
        checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        checkOutput("post_rst_no_issue", 32'(ep_addr.size() - base_ep), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
